select_register_file: RTL and testbench
=======================================

Name: select_register_file

Overview:
- Write-enable steering block in the writeback stage of the vectorial ASIP.
- Routes the decoder's single register-write request (wreg) to either the scalar register file (enreg) or the vector register file (envec), selected by the vector flag (vf).
- Steering is purely combinational, so the enables are valid in the same cycle the control arrives.
- Also keeps small clocked status: last write target, plus scalar and vector write counters for debug and performance visibility.

Parameters:
- CNT_W, 16, width of each write counter (1..32).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset (sampled on rising clk).
- wreg  input  1  register write request from control unit.
- vf  input  1  vector flag: 1 = destination is vector RF, 0 = scalar RF.
- enreg  output  1  scalar register file write enable.
- envec  output  1  vector register file write enable.
- last_vec  output  1  1 if the most recent committed write went to the vector RF.
- sca_cnt  output  CNT_W  number of committed scalar writes.
- vec_cnt  output  CNT_W  number of committed vector writes.

Behaviour:
- Steering (combinational, zero latency):
  - envec = wreg AND vf.
  - enreg = wreg AND NOT vf.
  - wreg=0 gives enreg=0 and envec=0, regardless of vf.
  - enreg and envec are never 1 simultaneously.
- enreg and envec do not depend on clk or rst.
  - They follow inputs even while rst is low and before any clock edge.
  - With no clock toggling, they must settle within the same timestep as an input change.
- X/Z on wreg or vf: outputs follow normal 4-state logic propagation. No special handling.
- Reset (rst=0 at a rising clk edge): last_vec=0, sca_cnt=0, vec_cnt=0. Reset has priority over any concurrent write in that cycle.
- Commit (rst=1, rising clk edge):
  - enreg=1: sca_cnt increments by 1 and last_vec becomes 0.
  - envec=1: vec_cnt increments by 1 and last_vec becomes 1.
  - wreg=0: no state change.
- Counters saturate at 2^CNT_W-1. There is no wrap-around; further writes leave the count at the maximum.
- Status outputs are registered. They reflect writes committed up to and including the previous rising edge (1-cycle latency relative to the enable).
- Reset mid-operation clears status on that edge only. Steering outputs are unaffected.
- Before the first reset, status register values are undefined and must not be relied upon.

Test Plan:
- Combinational vector select: wreg=1, vf=1, no clock, wait 10 time units -> envec=1, enreg=0.
- Combinational scalar select: wreg=1, then vf changes 1->0, wait 10 time units -> envec=0, enreg=1.
- No-write case: wreg=0 with vf=0 and vf=1 -> enreg=0, envec=0. Over 5 clocks, counters unchanged and last_vec unchanged.
- Reset and count:
  - rst=0 for one edge -> sca_cnt=0, vec_cnt=0, last_vec=0.
  - Then with rst=1: 3 scalar writes followed by 2 vector writes (one per clock) -> sca_cnt=3, vec_cnt=2, last_vec=1.
  - One further scalar write -> last_vec=0.
- Saturation: CNT_W=2, 5 consecutive vector writes -> vec_cnt=3 after the third write and stays 3; sca_cnt=0.
- Reset priority: rst=0 with wreg=1, vf=1 on the same edge -> vec_cnt=0, last_vec=0, while envec=1 combinationally during that cycle.

Source files
------------

// File: rtl/select_register_file.sv
// Writeback write-enable steering between scalar and vector register files,
// with registered last-target and saturating per-file write counters.
module select_register_file #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wreg,
    input  logic             vf,
    output logic             enreg,
    output logic             envec,
    output logic             last_vec,
    output logic [CNT_W-1:0] sca_cnt,
    output logic [CNT_W-1:0] vec_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Zero-latency steering; independent of clock and reset by design.
    assign envec = wreg & vf;
    assign enreg = wreg & ~vf;

    // Status: reset wins over a same-edge write; counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_vec <= 1'b0;
            sca_cnt  <= '0;
            vec_cnt  <= '0;
        end else if (enreg) begin
            last_vec <= 1'b0;
            if (sca_cnt != CNT_MAX) begin
                sca_cnt <= sca_cnt + CNT_W'(1);
            end
        end else if (envec) begin
            last_vec <= 1'b1;
            if (vec_cnt != CNT_MAX) begin
                vec_cnt <= vec_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_select_register_file.sv
// Randomized self-checking bench for select_register_file: a 16-bit and a 2-bit
// counter instance share stimulus and are checked against an integer model.
module tb_select_register_file;

    logic        clk = 1'b0;
    bit          clk_en = 1'b0;
    logic        rst = 1'b1;
    logic        wreg = 1'b0;
    logic        vf = 1'b0;

    logic        enreg, envec, last_vec;
    logic [15:0] sca_cnt, vec_cnt;
    logic        enreg2, envec2, last_vec2;
    logic [1:0]  sca_cnt2, vec_cnt2;

    int checks = 0;
    int errors = 0;

    // model state
    bit model_valid = 1'b0;
    int m_sca16 = 0, m_vec16 = 0, m_sca2 = 0, m_vec2 = 0;
    bit m_last = 1'b0;

    select_register_file #(.CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .wreg(wreg), .vf(vf),
        .enreg(enreg), .envec(envec), .last_vec(last_vec),
        .sca_cnt(sca_cnt), .vec_cnt(vec_cnt)
    );

    select_register_file #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .wreg(wreg), .vf(vf),
        .enreg(enreg2), .envec(envec2), .last_vec(last_vec2),
        .sca_cnt(sca_cnt2), .vec_cnt(vec_cnt2)
    );

    initial begin
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: counts writes per destination with saturation.
    always @(posedge clk) begin
        if (rst === 1'b0) begin
            m_sca16 = 0; m_vec16 = 0; m_sca2 = 0; m_vec2 = 0;
            m_last = 1'b0;
            model_valid = 1'b1;
        end else if (wreg === 1'b1) begin
            if (vf === 1'b1) begin
                if (m_vec16 < 65535) m_vec16++;
                if (m_vec2 < 3) m_vec2++;
                m_last = 1'b1;
            end else begin
                if (m_sca16 < 65535) m_sca16++;
                if (m_sca2 < 3) m_sca2++;
                m_last = 1'b0;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        check("enreg", 32'(enreg), 32'(wreg & ~vf));
        check("envec", 32'(envec), 32'(wreg & vf));
        check("enreg2", 32'(enreg2), 32'(wreg & ~vf));
        check("envec2", 32'(envec2), 32'(wreg & vf));
        if (model_valid) begin
            check("sca_cnt", 32'(sca_cnt), 32'(m_sca16));
            check("vec_cnt", 32'(vec_cnt), 32'(m_vec16));
            check("last_vec", 32'(last_vec), 32'(m_last));
            check("sca_cnt2", 32'(sca_cnt2), 32'(m_sca2));
            check("vec_cnt2", 32'(vec_cnt2), 32'(m_vec2));
            check("last_vec2", 32'(last_vec2), 32'(m_last));
        end
    end

    task automatic step(input logic r, input logic w, input logic v);
        rst = r; wreg = w; vf = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Steering with no clock running
        wreg = 1'b1; vf = 1'b1;
        #10;
        check("comb_vec_envec", 32'(envec), 32'd1);
        check("comb_vec_enreg", 32'(enreg), 32'd0);
        vf = 1'b0;
        #10;
        check("comb_sca_envec", 32'(envec), 32'd0);
        check("comb_sca_enreg", 32'(enreg), 32'd1);
        wreg = 1'b0; vf = 1'b0;
        #1;
        check("nowr0", 32'({enreg, envec}), 32'd0);
        vf = 1'b1;
        #1;
        check("nowr1", 32'({enreg, envec}), 32'd0);
        rst = 1'b0; wreg = 1'b1;
        #1;
        check("comb_in_reset", 32'({enreg, envec}), 32'd1);

        // Reset edge with a concurrent vector write: reset wins
        clk_en = 1'b1;
        step(1'b0, 1'b1, 1'b1);
        check("rst_sca", 32'(sca_cnt), 32'd0);
        check("rst_vec", 32'(vec_cnt), 32'd0);
        check("rst_last", 32'(last_vec), 32'd0);

        // 3 scalar then 2 vector writes
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b1);
        check("seq_sca", 32'(sca_cnt), 32'd3);
        check("seq_vec", 32'(vec_cnt), 32'd2);
        check("seq_last", 32'(last_vec), 32'd1);
        step(1'b1, 1'b1, 1'b0);
        check("seq_last_sca", 32'(last_vec), 32'd0);
        check("seq_sca4", 32'(sca_cnt), 32'd4);

        // Idle: nothing changes
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, i[0]);
        check("idle_sca", 32'(sca_cnt), 32'd4);
        check("idle_vec", 32'(vec_cnt), 32'd2);
        check("idle_last", 32'(last_vec), 32'd0);

        // Saturation on the 2-bit instance
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b1);
            if (i == 2) check("sat_vec2_3rd", 32'(vec_cnt2), 32'd3);
        end
        check("sat_vec2_end", 32'(vec_cnt2), 32'd3);
        check("sat_sca2", 32'(sca_cnt2), 32'd0);
        check("sat_vec16", 32'(vec_cnt), 32'd5);

        // Randomized traffic with occasional mid-stream resets
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
